// File: rtl/button_event_gen_pkg.sv
// Shared state encoding for the key event generator; import this from any
// multi-button wrapper so every channel decodes state the same way.
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

endpackage

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/repeat pulses and a
// long-press flag. All outputs are registered.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | key up, waiting for level=1
//   ST_HELD   | key down, counting toward the hold threshold
//   ST_REPEAT | key held past threshold, long_press high, periodic repeats
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int HOLD_N   = 50_000_000,
    parameter int REPEAT_N = 10_000_000,
    parameter int K        = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic repeat_en,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic long_press
);

    localparam logic [K-1:0] HOLD_TC   = K'(HOLD_N - 1);
    localparam logic [K-1:0] REPEAT_TC = K'(REPEAT_N - 1);

    state_e       state_q, state_d;
    logic [K-1:0] count_q, count_d;
    logic         press_pulse_q, press_pulse_d;
    logic         release_pulse_q, release_pulse_d;
    logic         repeat_pulse_q, repeat_pulse_d;
    logic         long_press_q, long_press_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_pulse_q  <= 1'b0;
            long_press_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            repeat_pulse_q  <= repeat_pulse_d;
            long_press_q    <= long_press_d;
        end
    end

    // Release is checked first in HELD/REPEAT so it wins over a threshold hit.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        repeat_pulse_d  = 1'b0;
        long_press_d    = long_press_q;

        case (state_q)
            ST_IDLE: begin
                long_press_d = 1'b0;
                if (level) begin
                    state_d       = ST_HELD;
                    press_pulse_d = 1'b1;
                    count_d       = '0;
                end
            end
            ST_HELD: begin
                if (!level) begin
                    state_d         = ST_IDLE;
                    release_pulse_d = 1'b1;
                end else if (count_q == HOLD_TC) begin
                    state_d        = ST_REPEAT;
                    long_press_d   = 1'b1;
                    repeat_pulse_d = 1'b1;
                    count_d        = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!level) begin
                    state_d         = ST_IDLE;
                    release_pulse_d = 1'b1;
                    long_press_d    = 1'b0;
                end else if (count_q == REPEAT_TC) begin
                    // Counter keeps its phase even while repeats are masked.
                    count_d        = '0;
                    repeat_pulse_d = repeat_en;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                count_d      = '0;
                long_press_d = 1'b0;
            end
        endcase
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;
    assign long_press    = long_press_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with HOLD_N=8, REPEAT_N=4, K=4.
// Observed vector is {press, release, repeat, long}; k counts cycles after press edge.
module tb_button_event_gen;

    logic clk;
    logic reset;
    logic level;
    logic repeat_en;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic long_press;
    logic [3:0] obs;
    logic [3:0] exp_v;

    int total;
    int bad;

    button_event_gen #(
        .HOLD_N  (8),
        .REPEAT_N(4),
        .K       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .level        (level),
        .repeat_en    (repeat_en),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .long_press   (long_press)
    );

    assign obs = {press_pulse, release_pulse, repeat_pulse, long_press};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        level = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        level     = 1'b0;
        repeat_en = 1'b1;
        #1;
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async obs=%b exp=%b", obs, 4'b0000);
        end
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset_idle k=%0d obs=%b exp=%b", k, obs, 4'b0000);
            end
        end
    endtask

    task automatic test_short_press();
        for (int k = 0; k < 6; k++) begin
            level = (k < 3);
            step();
            exp_v = {k == 0, k == 3, 1'b0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL short_press k=%0d obs=%b exp=%b", k, obs, exp_v);
            end
        end
        idle(2);
    endtask

    task automatic test_hold(input logic en);
        repeat_en = en;
        for (int k = 0; k < 25; k++) begin
            level = (k < 20);
            step();
            exp_v[3] = (k == 0);
            exp_v[2] = (k == 20);
            exp_v[1] = (k == 8) || (en && (k == 12 || k == 16));
            exp_v[0] = (k >= 8) && (k < 20);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL hold_en%0d k=%0d obs=%b exp=%b", en, k, obs, exp_v);
            end
        end
        repeat_en = 1'b1;
        idle(2);
    endtask

    task automatic test_release_at_threshold();
        for (int k = 0; k < 12; k++) begin
            level = (k < 8);
            step();
            exp_v = {k == 0, k == 8, 1'b0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL release_at_tc k=%0d obs=%b exp=%b", k, obs, exp_v);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            level = (k == 0) || (k == 2);
            step();
            exp_v = {(k == 0) || (k == 2), (k == 1) || (k == 3), 1'b0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL back_to_back k=%0d obs=%b exp=%b", k, obs, exp_v);
            end
        end
        idle(2);
    endtask

    task automatic test_repeat_en_phase();
        for (int k = 0; k < 33; k++) begin
            level     = (k < 30);
            repeat_en = !((k >= 10) && (k <= 13));
            step();
            exp_v[3] = (k == 0);
            exp_v[2] = (k == 30);
            exp_v[1] = (k == 8) || (k == 16) || (k == 20) || (k == 24) || (k == 28);
            exp_v[0] = (k >= 8) && (k < 30);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL repeat_en_phase k=%0d obs=%b exp=%b", k, obs, exp_v);
            end
        end
        repeat_en = 1'b1;
        idle(2);
    endtask

    task automatic test_reset_mid_hold();
        level = 1'b1;
        for (int k = 0; k <= 10; k++) step();
        total++;
        if (obs !== 4'b0001) begin
            bad++;
            $display("FAIL mid_hold_pre obs=%b exp=%b", obs, 4'b0001);
        end
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL mid_hold_async obs=%b exp=%b", obs, 4'b0000);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL mid_hold_in_reset k=%0d obs=%b exp=%b", k, obs, 4'b0000);
            end
        end
        reset = 1'b0;
        for (int j = 0; j < 11; j++) begin
            step();
            exp_v = {j == 0, 1'b0, j == 8, j >= 8};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL mid_hold_repress j=%0d obs=%b exp=%b", j, obs, exp_v);
            end
        end
        idle(3);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        level     = 1'b0;
        repeat_en = 1'b1;
        test_reset();
        test_short_press();
        test_hold(1'b1);
        test_hold(1'b0);
        test_release_at_threshold();
        test_back_to_back();
        test_repeat_en_phase();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
